// File: rtl/fbcpu_pkg.sv
// rtl/fbcpu_pkg.sv - shared FB-CPU widths, responder state encoding and opcodes
package fbcpu_pkg;

  localparam int FB_ADDRESS_WIDTH = 6;
  localparam int FB_DATA_WIDTH    = 10;
  localparam int FB_DEPTH         = 2 ** FB_ADDRESS_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } resp_state_t;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_JMP   = 4'd6;
  localparam logic [3:0] OP_JZ    = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd9;

endpackage

// File: rtl/fbcpu_ram_array.sv
// rtl/fbcpu_ram_array.sv - single write port, single registered read port RAM
module fbcpu_ram_array #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int WORD_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [WORD_WIDTH-1:0]    wdata,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  input  logic                     rd_clr,
  output logic [WORD_WIDTH-1:0]    rdata
);

  logic [WORD_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  // Write port: no reset on the storage itself, the responder's clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: samples the old contents on a same-address write; forced to 0 while clearing.
  always_ff @(posedge clk) begin
    if (rd_clr) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/fbcpu_ram_responder.sv
// rtl/fbcpu_ram_responder.sv - FB-CPU RAM responder with auto-clear and loader port (option: FBCPU_RAM_PARITY_EN)
module fbcpu_ram_responder
  import fbcpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FB_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = FB_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] MAR,
  input  logic                     RAMWr,
  input  logic [DATA_WIDTH-1:0]    MDRIn,
  output logic [DATA_WIDTH-1:0]    MDROut,
  output logic                     mem_busy,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]    load_data,
  output logic                     parity_err
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
`ifdef FBCPU_RAM_PARITY_EN
  localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
  localparam int WORD_WIDTH = DATA_WIDTH;
`endif

  resp_state_t              state, next_state;
  logic [ADDRESS_WIDTH-1:0] clr_addr;
  logic                     clr_last;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [WORD_WIDTH-1:0]    wword;
  logic [WORD_WIDTH-1:0]    rword;

  assign clr_last   = (clr_addr == ADDRESS_WIDTH'(DEPTH - 1));
  assign mem_busy   = (state == CLEAR);
  assign load_ready = (state == READY) && !RAMWr;

  // State register: any reset edge restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= next_state;
  end

  // Next state: leave CLEAR on the edge that writes the last word.
  always_comb begin
    next_state = state;
    if (state == CLEAR && clr_last) next_state = READY;
  end

  // Clear address counter; wraps back to 0 as the sweep finishes.
  always_ff @(posedge clk) begin
    if (rst)                 clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + ADDRESS_WIDTH'(1);
  end

  // Write-port mux, priority clear > CPU > loader; nothing is written on a reset edge.
  always_comb begin
    we    = 1'b0;
    waddr = clr_addr;
    wdata = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        we = 1'b1;
      end else if (RAMWr) begin
        we    = 1'b1;
        waddr = MAR;
        wdata = MDRIn;
      end else if (load_valid) begin
        we    = 1'b1;
        waddr = load_addr;
        wdata = load_data;
      end
    end
  end

`ifdef FBCPU_RAM_PARITY_EN
  logic err_q;
  logic mismatch;

  assign wword    = {^wdata, wdata};
  assign mismatch = ^rword;
  assign parity_err = err_q | mismatch;

  // Sticky parity error: the registered word is checked as soon as it appears on MDROut.
  always_ff @(posedge clk) begin
    if (rst)           err_q <= 1'b0;
    else if (mismatch) err_q <= 1'b1;
  end
`else
  assign wword      = wdata;
  assign parity_err = 1'b0;
`endif

  assign MDROut = rword[DATA_WIDTH-1:0];

  fbcpu_ram_array #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .WORD_WIDTH   (WORD_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wword),
    .raddr (MAR),
    .rd_clr(rst || (state == CLEAR)),
    .rdata (rword)
  );

endmodule

// File: doc/fbcpu_ram_responder.md
Name: fbcpu_ram_responder

Overview:
- Memory-side responder for the FB-CPU memory bus: it owns the 2**ADDRESS_WIDTH x DATA_WIDTH program/data RAM.
- Answers the CPU's combinational MAR/RAMWr/MDRIn requests with registered read data one cycle later.
- After reset it auto-clears the whole array while holding the CPU off.
- Provides a valid/ready loader port so a testbench or boot block can deposit a program image once the clear finishes.

Parameters:
- ADDRESS_WIDTH, 6, address bits; DEPTH = 2**ADDRESS_WIDTH words (64).
- DATA_WIDTH, 10, word width (4-bit opcode + 6-bit operand).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- MAR  input  ADDRESS_WIDTH  CPU address (read and write).
- RAMWr  input  1  CPU write strobe.
- MDRIn  input  DATA_WIDTH  CPU write data.
- MDROut  output  DATA_WIDTH  registered read data, returned to the CPU.
- mem_busy  output  1  high while clearing; system ORs it into the CPU's rst.
- load_valid  input  1  loader request.
- load_ready  output  1  loader may write this cycle.
- load_addr  input  ADDRESS_WIDTH  loader address.
- load_data  input  DATA_WIDTH  loader data.
- parity_err  output  1  sticky read-parity error (see Optional Feature).

Behaviour:
- Two states: CLEAR, READY. All state is updated on posedge clk only; reset is synchronous.
- Reset: rst high at an edge forces state=CLEAR, clr_addr=0, MDROut=0, parity_err=0. mem_busy=1 whenever state==CLEAR. Array contents are not reset directly; CLEAR overwrites them.
- CLEAR timing:
  - Each edge with rst low writes 0 to mem[clr_addr] and increments clr_addr.
  - On the edge that writes DEPTH-1, state goes to READY.
  - mem_busy falls exactly DEPTH (64) edges after the last edge with rst high.
  - CPU and loader inputs are ignored in CLEAR; MDROut holds 0.
- rst asserted mid-CLEAR or mid-READY restarts CLEAR from address 0 on that edge.
- READY read path:
  - Every edge: MDROut <= mem[MAR]. Read latency is 1 cycle, matching the CPU's fetch/execute split (MAR presented in one state, MDROut sampled in the next).
  - Read-before-write: a CPU write to address A and a read of A on the same edge returns the OLD contents of A.
- CPU write: edge with RAMWr=1 in READY performs mem[MAR] <= MDRIn.
- Loader port:
  - load_ready = (state==READY) && !RAMWr, combinational.
  - A load is accepted on an edge where load_valid && load_ready: mem[load_addr] <= load_data.
  - If RAMWr=1 the CPU write wins and the loader stalls; load_valid, load_addr and load_data must be held until accepted.
  - A loader write does not disturb the MDROut update from MAR on the same edge.
  - A loader write and a CPU read of the same address on the same edge: read returns old data.
- Addresses span exactly DEPTH words, so there is no out-of-range case and no wrap logic beyond the natural ADDRESS_WIDTH truncation of clr_addr.

Optional Feature:
- Macro FBCPU_RAM_PARITY_EN.
- When defined:
  - Each stored word carries one extra even-parity bit (^data), computed on CPU, loader and clear writes.
  - Every READY read recomputes parity. On a mismatch, parity_err is set on the edge that registers that MDROut and stays set until rst.
  - MDROut still returns the stored data bits unchanged.
- When undefined: no extra storage bit; parity_err is tied 0.

Decomposition:
- Package fbcpu_pkg holds:
  - ADDRESS_WIDTH/DATA_WIDTH defaults and derived DEPTH.
  - Responder state encoding (CLEAR=0, READY=1).
  - Opcode constants (LOAD=0, STORE=1, ADD=2, SUB=3, MUL=4, JMP=6, JZ=7, HALT=9), shared with the CPU and the bench.
- One sub-module, fbcpu_ram_array:
  - Single write port, single synchronous read port, width DATA_WIDTH (+1 with parity).
- Responder top holds the state machine, clr_addr counter, write-port mux (clear > CPU > loader) and the parity checker.

Test Plan:
1. Reset clear: pulse rst 1 cycle, then hold low → mem_busy high for exactly 64 cycles, then low; MAR=0..63 reads all return 0x000 one cycle after each address.
2. Loader and readback:
   - In READY, load addr 5 = 0x143 and addr 6 = 0x1FF with load_valid held → each accepted in 1 cycle (load_ready=1).
   - MAR=5 → MDROut=0x143 on the next edge.
3. Write/load collision: RAMWr=1, MAR=10, MDRIn=0x2AA while load_valid=1, addr 11 = 0x055 → load_ready=0 that cycle; mem[10]=0x2AA; load accepted the following cycle; mem[11]=0x055.
4. Read-before-write: mem[20]=0x011; same edge RAMWr=1, MAR=20, MDRIn=0x3FF → MDROut=0x011; next cycle MAR=20 → MDROut=0x3FF.
5. Reset mid-operation: assert rst at clear cycle 30 → clr_addr restarts at 0; mem_busy stays high a further 64 cycles; a loader write to addr 3 = 0x0F0 attempted during CLEAR is dropped (addr 3 reads 0x000).
6. Parity (FBCPU_RAM_PARITY_EN): load addr 7 = 0x001, flip stored data bit 0 by hierarchical deposit, read MAR=7 → MDROut=0x000 and parity_err=1 on the same edge, and it stays 1 until rst. Without the macro the same stimulus leaves parity_err=0.
